// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_rx_pkg;

    localparam int DATA_W = 8;

    localparam logic [5:0] PRESCALE_4  = 6'd4;
    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fsm.sv
// Frame sequencer for uart_rx: state register, per-bit edge counter and data bit counter.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level; the detecting cycle is count 0 of the start bit
// START  | qualifying the start bit; a high sample aborts back to IDLE
// DATA   | receiving D0..D7, LSB first
// PARITY | receiving the parity bit
// STOP   | receiving the stop bit; leaves right after its sample is evaluated
import uart_rx_pkg::*;

module uart_rx_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [5:0] prescale,
    input  logic       par_en,
    input  logic       bit_eval,
    input  logic       bit_val,
    output rx_state_e  state,
    output logic [5:0] edge_cnt,
    output logic [2:0] bit_cnt,
    output logic       start_det
);

    rx_state_e  state_nxt;
    logic [5:0] cnt_nxt;
    logic [2:0] bit_nxt;
    logic       bit_end;

    assign bit_end = (edge_cnt == prescale - 6'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            edge_cnt <= 6'd0;
            bit_cnt  <= 3'd0;
        end else begin
            state    <= state_nxt;
            edge_cnt <= cnt_nxt;
            bit_cnt  <= bit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = edge_cnt + 6'd1;
        bit_nxt   = bit_cnt;
        start_det = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = 6'd0;
                bit_nxt = 3'd0;
                if (!rx) begin
                    start_det = 1'b1;
                    state_nxt = START;
                    cnt_nxt   = 6'd1;
                end
            end
            START: begin
                // A glitch check wins over the bit-end transition when both land on one count (P=4).
                if (bit_eval && bit_val) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 6'd0;
                end else if (bit_end) begin
                    state_nxt = DATA;
                    cnt_nxt   = 6'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt = 6'd0;
                    if (bit_cnt == 3'd7) begin
                        bit_nxt   = 3'd0;
                        state_nxt = par_en ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    cnt_nxt   = 6'd0;
                end
            end
            STOP: begin
                if (bit_eval) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 6'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 6'd0;
                bit_nxt   = 3'd0;
            end
        endcase
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1 / 8E1 / 8O1 frames, runtime prescale 4/8/16/32.
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote around mid-bit instead of a single mid-bit sample.
import uart_rx_pkg::*;

module uart_rx (
    input  logic              clk,
    input  logic              rst,
    input  logic              RX_IN,
    input  logic [5:0]        prescale,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic [DATA_W-1:0] P_DATA
);

    rx_state_e         state;
    logic [5:0]        edge_cnt;
    logic [2:0]        bit_cnt;
    logic              start_det;
    logic [5:0]        p_lat;
    logic              pe_lat;
    logic              pt_lat;
    logic [5:0]        half_cnt;
    logic              bit_eval;
    logic              bit_val;
    logic              samp_mid;
    logic [DATA_W-1:0] shift_reg;
    logic              par_pend;
    logic              par_exp;

    assign half_cnt = p_lat >> 1;
    // All bit decisions happen on the last of the three sample counts, in both build variants.
    assign bit_eval = (edge_cnt == half_cnt + 6'd1);

    uart_rx_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .rx        (RX_IN),
        .prescale  (p_lat),
        .par_en    (pe_lat),
        .bit_eval  (bit_eval),
        .bit_val   (bit_val),
        .state     (state),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .start_det (start_det)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_lat  <= PRESCALE_4;
            pe_lat <= 1'b0;
            pt_lat <= 1'b0;
        end else if (start_det) begin
            p_lat  <= prescale;
            pe_lat <= PAR_EN;
            pt_lat <= PAR_TYP;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic samp_early;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_early <= 1'b1;
            samp_mid   <= 1'b1;
        end else begin
            if (edge_cnt == half_cnt - 6'd1) samp_early <= RX_IN;
            if (edge_cnt == half_cnt)        samp_mid   <= RX_IN;
        end
    end

    assign bit_val = majority3(samp_early, samp_mid, RX_IN);
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp_mid <= 1'b1;
        end else if (edge_cnt == half_cnt) begin
            samp_mid <= RX_IN;
        end
    end

    assign bit_val = samp_mid;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
        end else if (state == DATA && bit_eval) begin
            shift_reg[bit_cnt] <= bit_val;
        end
    end

    assign par_exp = pt_lat ? ~^shift_reg : ^shift_reg;

    // Error flags are cleared only once a start bit is confirmed, so a line glitch leaves them intact.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            par_pend   <= 1'b0;
            P_DATA     <= '0;
        end else begin
            data_valid <= 1'b0;
            if (state == START && bit_eval && !bit_val) begin
                par_err  <= 1'b0;
                stp_err  <= 1'b0;
                par_pend <= 1'b0;
            end
            if (state == PARITY && bit_eval) begin
                par_pend <= (bit_val != par_exp);
            end
            if (state == STOP && bit_eval) begin
                if (bit_val && !par_pend) begin
                    P_DATA     <= shift_reg;
                    data_valid <= 1'b1;
                end
                if (!bit_val) stp_err <= 1'b1;
                if (par_pend) par_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: random frames from a bit-level line model, monitor pops expected bytes.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic [7:0] P_DATA;

    int         n_tests = 0;
    int         n_fail = 0;
    int         dv_count = 0;
    int         p_cur = 8;
    time        last_stop_t = 0;
    logic       dv_prev = 1'b0;
    logic [7:0] model_pdata = 8'h00;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .prescale   (prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .P_DATA     (P_DATA)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Hold the line at level b for exactly p clock periods.
    task automatic drive_bit(input logic b, input int p);
        @(negedge clk);
        RX_IN = b;
        repeat (p - 1) @(negedge clk);
    endtask

    task automatic idle_bits(input int p, input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1, p);
    endtask

    task automatic send_frame(input int p, input bit pe, input bit pt, input logic [7:0] d,
                              input bit flip_par, input logic stop_val);
        int ones;
        bit pbit;
        bit good;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        // Parity bit chosen so the total count of ones is even (pt=0) or odd (pt=1).
        pbit = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
        pbit = pbit ^ flip_par;
        good = (stop_val == 1'b1) && !(pe && flip_par);
        @(negedge clk);
        prescale = 6'(p);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        p_cur    = p;
        RX_IN    = 1'b0;
        if (good) begin
            exp_q.push_back(d);
            model_pdata = d;
        end
        repeat (p - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pe) drive_bit(pbit, p);
        @(negedge clk);
        RX_IN = stop_val;
        last_stop_t = $time;
        repeat (p - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_count++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_dv: data_valid with P_DATA=0x%0h, expected no strobe", P_DATA);
            end else begin
                check("p_data", int'(P_DATA), int'(exp_q.pop_front()));
            end
            check("dv_err_flags", int'({par_err, stp_err}), 0);
            check("dv_one_cycle", int'(dv_prev), 0);
            check("dv_in_stop_bit",
                  int'(($time > last_stop_t) && (($time - last_stop_t) <= 10 * p_cur)), 1);
        end
        dv_prev = data_valid;
    end

    initial begin
        int plist[3];
        int base;
        logic [7:0] b;
        plist[0] = 8;
        plist[1] = 16;
        plist[2] = 32;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_dv", int'(data_valid), 0);
        check("reset_par_err", int'(par_err), 0);
        check("reset_stp_err", int'(stp_err), 0);
        check("reset_p_data", int'(P_DATA), 0);

        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(4, 1'b1, 1'b0, b, 1'b0, 1'b1);
        end
        idle_bits(4, 3);
        check("drain_p4", exp_q.size(), 0);
        check("flags_p4", int'({par_err, stp_err}), 0);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5; i++) begin
                b = 8'($urandom_range(0, 255));
                send_frame(plist[k], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b, 1'b0, 1'b1);
            end
            for (int i = 0; i < 5; i++) begin
                b = 8'($urandom_range(0, 255));
                send_frame(plist[k], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), b, 1'b0, 1'b1);
                idle_bits(plist[k], int'($urandom_range(2, 4)));
            end
            idle_bits(plist[k], 2);
            check("drain_group", exp_q.size(), 0);
            check("p_data_hold", int'(P_DATA), int'(model_pdata));
        end
        check("dv_total", dv_count, 35);

        base = dv_count;
        send_frame(8, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
        idle_bits(8, 3);
        check("stop_err_set", int'(stp_err), 1);
        check("stop_err_no_par", int'(par_err), 0);
        check("stop_err_no_dv", dv_count, base);
        check("stop_err_p_data", int'(P_DATA), int'(model_pdata));

        send_frame(8, 1'b1, 1'b1, 8'h07, 1'b1, 1'b1);
        idle_bits(8, 2);
        check("odd_par_err", int'(par_err), 1);
        check("odd_stp_cleared", int'(stp_err), 0);
        check("odd_no_dv", dv_count, base);
        check("odd_p_data", int'(P_DATA), int'(model_pdata));

        send_frame(8, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1);
        idle_bits(8, 2);
        check("even_par_err", int'(par_err), 1);
        check("even_no_dv", dv_count, base);
        check("even_p_data", int'(P_DATA), int'(model_pdata));

        @(negedge clk);
        RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        RX_IN = 1'b1;
        idle_bits(8, 3);
        check("glitch_par_err_kept", int'(par_err), 1);
        check("glitch_stp_err", int'(stp_err), 0);
        check("glitch_no_dv", dv_count, base);
        check("glitch_p_data", int'(P_DATA), int'(model_pdata));

        b = 8'($urandom_range(0, 255));
        send_frame(8, 1'b0, 1'b0, b, 1'b0, 1'b1);
        idle_bits(8, 2);
        check("recover_drain", exp_q.size(), 0);
        check("recover_par_err", int'(par_err), 0);
        check("recover_p_data", int'(P_DATA), int'(b));

        base = dv_count;
        @(negedge clk);
        RX_IN = 1'b0;
        repeat (8 * 3) @(negedge clk);
        rst = 1'b0;
        #1;
        model_pdata = 8'h00;
        check("midreset_p_data", int'(P_DATA), 0);
        check("midreset_flags", int'({data_valid, par_err, stp_err}), 0);
        @(negedge clk);
        RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        idle_bits(8, 12);
        check("midreset_no_dv", dv_count, base);
        check("midreset_p_data_after", int'(P_DATA), int'(model_pdata));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
